// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: sends preamble, payload (MSB first) and an even-parity
// bit on y_out, one bit per clock, after a valid/ready accept.
module serial_frame_tx #(
    parameter int unsigned      DATA_W   = 8,
    parameter int unsigned      PRE_W    = 4,
    parameter logic [PRE_W-1:0] PREAMBLE = 4'b1011,
    parameter logic             IDLE_BIT = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              y_out,
    output logic              frame_out,
    output logic              done_out
);

    localparam int unsigned MAX_W = (PRE_W > DATA_W) ? PRE_W : DATA_W;
    localparam int unsigned CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int unsigned FW    = PRE_W + DATA_W + 1;

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        PAR,
        GAP
    } state_t;

    state_t          state_q;
    logic [FW-1:0]   sh_q;
    logic [CNT_W-1:0] cnt_q;
    logic            y_q;
    logic            frame_q;
    logic            done_q;
    logic [FW-1:0]   load_d;

    // Whole frame (preamble, payload, parity) lives in one shift register;
    // the counter only tracks where the PRE/DATA boundaries fall.
    always_comb begin
        load_d = {PREAMBLE, data_in, ^data_in};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            y_q     <= IDLE_BIT;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        sh_q    <= load_d << 1;
                        y_q     <= PREAMBLE[PRE_W-1];
                        frame_q <= 1'b1;
                        cnt_q   <= PRE_LAST;
                        // A one-bit preamble enters PRE with cnt=0 and leaves it on the next edge.
                        state_q <= PRE;
                    end else begin
                        y_q <= IDLE_BIT;
                    end
                end
                PRE: begin
                    y_q  <= sh_q[FW-1];
                    sh_q <= sh_q << 1;
                    if (cnt_q == '0) begin
                        cnt_q   <= DATA_LAST;
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DATA: begin
                    y_q  <= sh_q[FW-1];
                    sh_q <= sh_q << 1;
                    if (cnt_q == '0) begin
                        state_q <= PAR;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                PAR: begin
                    y_q     <= IDLE_BIT;
                    frame_q <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= GAP;
                end
                GAP: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    y_q     <= IDLE_BIT;
                    frame_q <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_out = (state_q == IDLE);
    assign y_out     = y_q;
    assign frame_out = frame_q;
    assign done_out  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed self-checking bench for serial_frame_tx (default and 4-bit/3-bit-preamble builds).
module tb_serial_frame_tx;

    logic       clock;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out, y_out, frame_out, done_out;

    logic [3:0] d4;
    logic       v4;
    logic       r4, y4, f4, dn4;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    serial_frame_tx dut (
        .clock    (clock),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .y_out    (y_out),
        .frame_out(frame_out),
        .done_out (done_out)
    );

    serial_frame_tx #(
        .DATA_W  (4),
        .PRE_W   (3),
        .PREAMBLE(3'b110),
        .IDLE_BIT(1'b0)
    ) dut4 (
        .clock    (clock),
        .reset    (reset),
        .data_in  (d4),
        .valid_in (v4),
        .ready_out(r4),
        .y_out    (y4),
        .frame_out(f4),
        .done_out (dn4)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        total_cnt++;
        if ({y_out, frame_out, done_out, ready_out} !== 4'b0001) begin
            $display("FAIL reset_state: got %b expected %b", {y_out, frame_out, done_out, ready_out}, 4'b0001);
        end else pass_cnt++;
        total_cnt++;
        if ({y4, f4, dn4, r4} !== 4'b0001) begin
            $display("FAIL reset_state_w4: got %b expected %b", {y4, f4, dn4, r4}, 4'b0001);
        end else pass_cnt++;
        // valid during reset must not start a frame
        valid_in = 1'b1;
        data_in  = 8'hFF;
        tick();
        total_cnt++;
        if ({y_out, frame_out, done_out, ready_out} !== 4'b0001) begin
            $display("FAIL reset_no_accept: got %b expected %b", {y_out, frame_out, done_out, ready_out}, 4'b0001);
        end else pass_cnt++;
        #2;
        reset    = 1'b0;
        valid_in = 1'b0;
        tick();
    endtask

    task automatic run_frame(input logic [7:0] d, input logic [12:0] exp, input bit disturb, input string name);
        total_cnt++;
        if (ready_out !== 1'b1) begin
            $display("FAIL %s_ready_pre: got %b expected 1", name, ready_out);
        end else pass_cnt++;
        data_in  = d;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        for (int i = 0; i < 13; i++) begin
            total_cnt++;
            if ({y_out, frame_out, done_out, ready_out} !== {exp[12-i], 3'b100}) begin
                $display("FAIL %s_bit%0d: got y/frame/done/ready=%b expected %b", name, i,
                         {y_out, frame_out, done_out, ready_out}, {exp[12-i], 3'b100});
            end else pass_cnt++;
            if (disturb) begin
                data_in  = ~data_in;
                valid_in = (i == 5);
            end
            tick();
        end
        valid_in = 1'b0;
        total_cnt++;
        if ({y_out, frame_out, done_out, ready_out} !== 4'b0010) begin
            $display("FAIL %s_done: got %b expected %b", name, {y_out, frame_out, done_out, ready_out}, 4'b0010);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if ({y_out, frame_out, done_out, ready_out} !== 4'b0001) begin
            $display("FAIL %s_idle: got %b expected %b", name, {y_out, frame_out, done_out, ready_out}, 4'b0001);
        end else pass_cnt++;
        if (disturb) begin
            tick();
            total_cnt++;
            if ({y_out, frame_out, ready_out} !== 3'b001) begin
                $display("FAIL %s_no_extra_frame: got %b expected %b", name, {y_out, frame_out, ready_out}, 3'b001);
            end else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp1;
        logic [12:0] exp2;
        exp1 = 13'b1011_11111111_0;
        exp2 = 13'b1011_00000000_0;
        data_in  = 8'hFF;
        valid_in = 1'b1;
        tick();
        data_in = 8'h00;
        for (int i = 0; i < 13; i++) begin
            total_cnt++;
            if ({y_out, frame_out} !== {exp1[12-i], 1'b1}) begin
                $display("FAIL b2b_ff_bit%0d: got y/frame=%b expected %b", i, {y_out, frame_out}, {exp1[12-i], 1'b1});
            end else pass_cnt++;
            tick();
        end
        total_cnt++;
        if ({y_out, frame_out, done_out, ready_out} !== 4'b0010) begin
            $display("FAIL b2b_gap1: got %b expected %b", {y_out, frame_out, done_out, ready_out}, 4'b0010);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if ({y_out, frame_out, done_out, ready_out} !== 4'b0001) begin
            $display("FAIL b2b_gap2: got %b expected %b", {y_out, frame_out, done_out, ready_out}, 4'b0001);
        end else pass_cnt++;
        tick();
        // 15 edges after the first accept the second frame must already be on the line
        total_cnt++;
        if ({y_out, frame_out, done_out, ready_out} !== 4'b1100) begin
            $display("FAIL b2b_second_accept: got %b expected %b", {y_out, frame_out, done_out, ready_out}, 4'b1100);
        end else pass_cnt++;
        valid_in = 1'b0;
        data_in  = 8'hFF;
        tick();
        for (int i = 1; i < 13; i++) begin
            total_cnt++;
            if ({y_out, frame_out} !== {exp2[12-i], 1'b1}) begin
                $display("FAIL b2b_00_bit%0d: got y/frame=%b expected %b", i, {y_out, frame_out}, {exp2[12-i], 1'b1});
            end else pass_cnt++;
            tick();
        end
        total_cnt++;
        if ({y_out, frame_out, done_out, ready_out} !== 4'b0010) begin
            $display("FAIL b2b_done2: got %b expected %b", {y_out, frame_out, done_out, ready_out}, 4'b0010);
        end else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid_frame();
        int unsigned bad;
        data_in  = 8'hA5;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        repeat (6) tick();
        total_cnt++;
        if ({y_out, frame_out} !== 2'b11) begin
            $display("FAIL midrst_data5: got y/frame=%b expected %b", {y_out, frame_out}, 2'b11);
        end else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({y_out, frame_out, done_out, ready_out} !== 4'b0001) begin
            $display("FAIL midrst_immediate: got %b expected %b", {y_out, frame_out, done_out, ready_out}, 4'b0001);
        end else pass_cnt++;
        tick();
        #2;
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done_out !== 1'b0 || frame_out !== 1'b0 || y_out !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad != 0) begin
            $display("FAIL midrst_no_resume: got %0d active cycles expected 0", bad);
        end else pass_cnt++;
        run_frame(8'h3C, 13'b1011_00111100_0, 1'b0, "after_rst");
    endtask

    task automatic test_width_override();
        logic [7:0] exp;
        exp = 8'b110_0111_1;
        total_cnt++;
        if (r4 !== 1'b1) begin
            $display("FAIL w4_ready_pre: got %b expected 1", r4);
        end else pass_cnt++;
        d4 = 4'b0111;
        v4 = 1'b1;
        tick();
        v4 = 1'b0;
        d4 = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if ({y4, f4, dn4, r4} !== {exp[7-i], 3'b100}) begin
                $display("FAIL w4_bit%0d: got %b expected %b", i, {y4, f4, dn4, r4}, {exp[7-i], 3'b100});
            end else pass_cnt++;
            tick();
        end
        total_cnt++;
        if ({y4, f4, dn4, r4} !== 4'b0010) begin
            $display("FAIL w4_done: got %b expected %b", {y4, f4, dn4, r4}, 4'b0010);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if ({y4, f4, dn4, r4} !== 4'b0001) begin
            $display("FAIL w4_idle: got %b expected %b", {y4, f4, dn4, r4}, 4'b0001);
        end else pass_cnt++;
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        v4       = 1'b0;
        d4       = 4'h0;
        #2;
        test_reset();
        run_frame(8'hA5, 13'b1011_10100101_0, 1'b0, "frame_a5");
        run_frame(8'h01, 13'b1011_00000001_1, 1'b0, "frame_01");
        test_back_to_back();
        run_frame(8'h5A, 13'b1011_01011010_0, 1'b1, "disturb");
        test_reset_mid_frame();
        test_width_override();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
